// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: serial datapath FSM states and default operand width.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: D = A - B - Bin, Bout set when the bit needs a borrow.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    assign D    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell, registered borrow, LSB first.
// Handshake: an operation is accepted on a rising edge where start = 1 and ready = 1;
// results are qualified by a one-cycle valid pulse and held until the next result.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             V
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic             a_msb;
    logic             b_msb;
    logic             d;
    logic             br_next;
    logic             last_bit;

    full_subtractor u_cell (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .Bin  (br),
        .D    (d),
        .Bout (br_next)
    );

    assign last_bit = (cnt == LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ready/valid are registered from the next state so no output is a decode of inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ready <= 1'b1;
            valid <= 1'b0;
        end else begin
            state <= state_next;
            ready <= (state_next == IDLE);
            valid <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            Diff   <= '0;
            Bout   <= 1'b0;
            V      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        br    <= Bin;
                        a_msb <= A[WIDTH-1];
                        b_msb <= B[WIDTH-1];
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= br_next;
                    res_sr <= {d, res_sr[WIDTH-1:1]};
                    // On the last bit d is the result MSB, so V can be formed without waiting.
                    if (last_bit) begin
                        Diff <= {d, res_sr[WIDTH-1:1]};
                        Bout <= br_next;
                        V    <= (a_msb ^ b_msb) & (a_msb ^ d);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH = 8 and WIDTH = 13.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start8 = 1'b0, bin8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ready8, valid8, bout8, v8;
    logic [7:0]  diff8;

    logic        start13 = 1'b0, bin13 = 1'b0;
    logic [12:0] a13 = '0, b13 = '0;
    logic        ready13, valid13, bout13, v13;
    logic [12:0] diff13;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Bin(bin8),
        .ready(ready8), .valid(valid8), .Diff(diff8), .Bout(bout8), .V(v8)
    );

    serial_subtractor #(.WIDTH(13)) dut13 (
        .clk(clk), .rst(rst), .start(start13), .A(a13), .B(b13), .Bin(bin13),
        .ready(ready13), .valid(valid13), .Diff(diff13), .Bout(bout13), .V(v13)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       v;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on unsigned and signed readings of the operands.
    task automatic model(input int w, input logic [12:0] a, input logic [12:0] b, input logic bin,
                         output logic [12:0] diff, output logic bout, output logic v);
        longint ua, ub, sa, sb, r, sr;
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= (64'sd1 << (w - 1))) ? ua - (64'sd1 << w) : ua;
        sb = (ub >= (64'sd1 << (w - 1))) ? ub - (64'sd1 << w) : ub;
        r  = ua - ub - longint'(bin);
        sr = sa - sb - longint'(bin);
        diff = 13'(r & ((64'sd1 << w) - 1));
        bout = (ua < ub + longint'(bin));
        v    = (sr < -(64'sd1 << (w - 1))) || (sr > (64'sd1 << (w - 1)) - 1);
    endtask

    function automatic logic get_ready(input int w);
        return (w == 8) ? ready8 : ready13;
    endfunction

    function automatic logic get_valid(input int w);
        return (w == 8) ? valid8 : valid13;
    endfunction

    task automatic drive(input int w, input logic s, input logic [12:0] a, input logic [12:0] b,
                         input logic bin);
        if (w == 8) begin
            start8 = s; a8 = a[7:0]; b8 = b[7:0]; bin8 = bin;
        end else begin
            start13 = s; a13 = a; b13 = b; bin13 = bin;
        end
    endtask

    // One full operation; lat = negedges from the accepting edge to the first valid, -1 on timeout.
    task automatic do_op(input int w, input logic [12:0] a, input logic [12:0] b, input logic bin,
                         output logic [12:0] diff, output logic bout, output logic v, output int lat);
        int guard;
        lat = -1;
        diff = '0; bout = 1'b0; v = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!get_ready(w) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!get_ready(w)) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        drive(w, 1'b1, a, b, bin);
        @(negedge clk);
        drive(w, 1'b0, '0, '0, 1'b0);
        for (int n = 1; n <= 40; n++) begin
            if (get_valid(w)) begin
                lat = n;
                if (w == 8) begin
                    diff = {5'b0, diff8}; bout = bout8; v = v8;
                end else begin
                    diff = diff13; bout = bout13; v = v13;
                end
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) chk("valid_timeout", 0, 1);
    endtask

    vec_t        vecs[6];
    logic [12:0] got_d, exp_d;
    logic        got_b, got_v, exp_b, exp_v;
    int          lat;
    int          pulses;
    int          last_pulse;
    int          gaps_ok;

    initial begin
        vecs[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, diff: 8'h02, bout: 1'b0, v: 1'b0};
        vecs[1] = '{a: 8'h03, b: 8'h05, bin: 1'b0, diff: 8'hFE, bout: 1'b1, v: 1'b0};
        vecs[2] = '{a: 8'h80, b: 8'h01, bin: 1'b0, diff: 8'h7F, bout: 1'b0, v: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'h00, bin: 1'b1, diff: 8'hFF, bout: 1'b1, v: 1'b0};
        vecs[4] = '{a: 8'hFF, b: 8'hFF, bin: 1'b0, diff: 8'h00, bout: 1'b0, v: 1'b0};
        vecs[5] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, diff: 8'h80, bout: 1'b1, v: 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", 32'(ready8), 1);
        chk("reset_valid", 32'(valid8), 0);
        chk("reset_diff", 32'(diff8), 0);
        chk("reset_bout", 32'(bout8), 0);
        chk("reset_v", 32'(v8), 0);

        foreach (vecs[i]) begin
            do_op(8, {5'b0, vecs[i].a}, {5'b0, vecs[i].b}, vecs[i].bin, got_d, got_b, got_v, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 9);
            chk($sformatf("vec%0d_diff", i), 32'(got_d), 32'(vecs[i].diff));
            chk($sformatf("vec%0d_bout", i), 32'(got_b), 32'(vecs[i].bout));
            chk($sformatf("vec%0d_v", i), 32'(got_v), 32'(vecs[i].v));
            @(negedge clk);
            chk($sformatf("vec%0d_ready_back", i), 32'(ready8), 1);
            chk($sformatf("vec%0d_valid_pulse", i), 32'(valid8), 0);
        end

        // start pulsed with other operands mid-RUN must be ignored.
        @(negedge clk);
        drive(8, 1'b1, 13'h05, 13'h03, 1'b0);
        @(negedge clk);
        drive(8, 1'b0, '0, '0, 1'b0);
        pulses = 0;
        for (int n = 1; n <= 25; n++) begin
            if (n == 3) drive(8, 1'b1, 13'hAA, 13'h11, 1'b1);
            if (n == 4) drive(8, 1'b0, '0, '0, 1'b0);
            if (valid8) begin
                pulses++;
                chk("busy_diff", 32'(diff8), 32'h02);
                chk("busy_when", 32'(n), 9);
            end
            @(negedge clk);
        end
        chk("busy_pulses", 32'(pulses), 1);
        chk("busy_diff_held", 32'(diff8), 32'h02);

        // start held high: back-to-back operations, one pulse per WIDTH+2 cycles.
        drive(8, 1'b1, 13'h80, 13'h01, 1'b0);
        pulses = 0; last_pulse = -1; gaps_ok = 1;
        for (int n = 0; n < 52; n++) begin
            @(negedge clk);
            if (valid8) begin
                if (last_pulse >= 0 && n - last_pulse != 10) gaps_ok = 0;
                last_pulse = n;
                pulses++;
            end
        end
        drive(8, 1'b0, '0, '0, 1'b0);
        chk("held_pulses", 32'(pulses), 5);
        chk("held_gap10", 32'(gaps_ok), 1);
        chk("held_diff", 32'(diff8), 32'h7F);
        chk("held_v", 32'(v8), 1);
        repeat (12) @(negedge clk);

        // Leave a non-zero result, then reset while bit 4 is being processed.
        do_op(8, 13'h03, 13'h05, 1'b0, got_d, got_b, got_v, lat);
        chk("pre_reset_diff", 32'(got_d), 32'hFE);
        @(negedge clk);
        @(negedge clk);
        drive(8, 1'b1, 13'h12, 13'h34, 1'b0);
        @(negedge clk);
        drive(8, 1'b0, '0, '0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_ready", 32'(ready8), 1);
        chk("midrun_valid", 32'(valid8), 0);
        chk("midrun_diff", 32'(diff8), 0);
        chk("midrun_bout", 32'(bout8), 0);
        chk("midrun_v", 32'(v8), 0);
        pulses = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (valid8) pulses++;
        end
        chk("midrun_no_pulse", 32'(pulses), 0);

        for (int w = 8; w <= 13; w += 5) begin
            for (int i = 0; i < 1000; i++) begin
                logic [12:0] ra, rb;
                logic        rbin;
                ra   = 13'($urandom_range(0, (1 << w) - 1));
                rb   = 13'($urandom_range(0, (1 << w) - 1));
                rbin = 1'($urandom_range(0, 1));
                model(w, ra, rb, rbin, exp_d, exp_b, exp_v);
                do_op(w, ra, rb, rbin, got_d, got_b, got_v, lat);
                chk($sformatf("rand_w%0d_lat", w), 32'(lat), 32'(w + 1));
                chk($sformatf("rand_w%0d_diff a=%0h b=%0h bin=%0d", w, ra, rb, rbin),
                    32'(got_d), 32'(exp_d));
                chk($sformatf("rand_w%0d_bout a=%0h b=%0h bin=%0d", w, ra, rb, rbin),
                    32'(got_b), 32'(exp_b));
                chk($sformatf("rand_w%0d_v a=%0h b=%0h bin=%0d", w, ra, rb, rbin),
                    32'(got_v), 32'(exp_v));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
